// File: rtl/rx_switch_arbiter.sv
// rx_switch_arbiter: router input half, PORTS buffered rx channels plus PORTS round-robin output arbiters
// Ports: clk, reset (async, active-high); rt_ready gates new grants;
//   rx_req/rx_ack/rx_data: 4-phase flit links, one 8-flit packet buffered per channel;
//   rt_addr/rt_data: external routing table lookup (header destination -> output index);
//   out_req/out_active/out_sel/out_done: grant interface to tx i;
//   out_buf_addr/out_buf_data: combinational read of the granted packet buffer.
// Define RX_ARB_DEBUG_EN for $display tracing of packet, route, discard, grant and release events.
module rx_switch_arbiter #(
  parameter int ID        = 0,
  parameter int PORTS     = 5,
  parameter int PORT_BITS = 8,
  parameter int SIZE      = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rt_ready,
  input  logic [PORTS-1:0]                rx_req,
  output logic [PORTS-1:0]                rx_ack,
  input  logic [PORTS*SIZE-1:0]           rx_data,
  output logic [PORTS*(SIZE-1)-1:0]       rt_addr,
  input  logic [PORTS*PORT_BITS-1:0]      rt_data,
  output logic [PORTS-1:0]                out_req,
  input  logic [PORTS-1:0]                out_done,
  output logic [PORTS*PORT_BITS-1:0]      out_sel,
  output logic [PORTS-1:0]                out_active,
  input  logic [PORTS*3-1:0]              out_buf_addr,
  output logic [PORTS*SIZE-1:0]           out_buf_data
);
  localparam int DEST_BITS = SIZE - 1;
  typedef enum logic [1:0] {RECV, ROUTE, REQ, SEND} rx_state_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  logic [PORTS-1:0] sw_req, sw_ack;
  logic [PORT_BITS-1:0] chnl [PORTS];
  logic [SIZE-1:0] flits [PORTS][8];
`ifdef RX_ARB_DEBUG_EN
  localparam int DBG_ID = ID;
`else
  logic [31:0] unused_id;
  assign unused_id = ID;
`endif
  always_comb begin
    sw_ack = '0;
    for (int i = 0; i < PORTS; i++)
      for (int j = 0; j < PORTS; j++)
        if (out_active[i] && out_sel[i*PORT_BITS +: PORT_BITS] == PORT_BITS'(j)) sw_ack[j] = 1'b1;
  end
  genvar g;
  for (g = 0; g < PORTS; g++) begin : rx
    rx_state_t state, state_nxt;
    logic [3:0] count;
    logic ack, take, drop, bad;
    logic [DEST_BITS-1:0] dest;
    logic [PORT_BITS-1:0] ch, route;
    logic [SIZE-1:0] mem [8];
    assign route = rt_data[g*PORT_BITS +: PORT_BITS];
    assign take = state == RECV && rx_req[g] && !ack && count < 4'd8;
    // The packet is complete only once the 8th flit's handshake has fully returned to zero.
    assign drop = state == RECV && ack && !rx_req[g];
    assign bad = route >= PORT_BITS'(PORTS);
    always_comb
      state_nxt = (drop && count == 4'd8) ? ROUTE :
                  state == ROUTE ? (bad ? RECV : REQ) :
                  (state == REQ && sw_ack[g]) ? SEND :
                  (state == SEND && !sw_ack[g]) ? RECV : state;
    always_ff @(posedge clk or posedge reset)
      if (reset) state <= RECV;
      else state <= state_nxt;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        count <= '0;
        ack <= 1'b0;
        dest <= '0;
        ch <= '0;
      end else begin
        if (take) begin
          count <= count + 4'd1;
          ack <= 1'b1;
          if (count == 4'd0) dest <= rx_data[g*SIZE +: DEST_BITS];
        end
        if (drop) ack <= 1'b0;
        if (state == ROUTE) ch <= route;
        if ((state == ROUTE && bad) || (state == SEND && !sw_ack[g])) begin
          count <= '0;
          dest <= '0;
        end
      end
    always_ff @(posedge clk)
      if (take) mem[count[2:0]] <= rx_data[g*SIZE +: SIZE];
    assign flits[g] = mem;
    assign chnl[g] = ch;
    assign rx_ack[g] = ack;
    assign rt_addr[g*DEST_BITS +: DEST_BITS] = dest;
    // Request drops as soon as the grant is withdrawn so a released packet is never re-granted.
    assign sw_req[g] = state == REQ || (state == SEND && sw_ack[g]);
`ifdef RX_ARB_DEBUG_EN
    always @(posedge clk)
      if (!reset) begin
        if (drop && count == 4'd8) $display("Router %0d: rx %0d packet complete, dest %0d", DBG_ID, g, dest);
        if (state == ROUTE && bad) $display("Router %0d: rx %0d discard, route %0d", DBG_ID, g, route);
        if (state == ROUTE && !bad) $display("Router %0d: rx %0d route lookup -> out %0d", DBG_ID, g, route);
      end
`else
`endif
  end
  for (g = 0; g < PORTS; g++) begin : arb
    arb_state_t state, state_nxt;
    logic [PORT_BITS-1:0] sel, ptr, pick;
    logic [PORTS-1:0] req;
    logic [SIZE-1:0] data;
    int rank, best;
    // Rank 1 is the channel right after the last winner; lowest rank among requesters wins.
    always_comb begin
      req = '0;
      pick = ptr;
      rank = 0;
      best = PORTS + 1;
      for (int j = 0; j < PORTS; j++) begin
        req[j] = sw_req[j] && chnl[j] == PORT_BITS'(g) && rt_ready;
        rank = j > int'(ptr) ? j - int'(ptr) : j - int'(ptr) + PORTS;
        if (req[j] && rank < best) begin
          best = rank;
          pick = PORT_BITS'(j);
        end
      end
    end
    always_comb
      state_nxt = (state == IDLE && |req) ? GRANT : (state == GRANT && out_done[g]) ? IDLE : state;
    always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nxt;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sel <= '0;
        ptr <= PORT_BITS'(PORTS - 1);
      end else if (state == IDLE && |req) sel <= pick;
      else if (state == GRANT && out_done[g]) ptr <= sel;
    always_comb begin
      data = '0;
      for (int j = 0; j < PORTS; j++)
        if (state == GRANT && sel == PORT_BITS'(j)) data = flits[j][out_buf_addr[g*3 +: 3]];
    end
    assign out_req[g] = state == GRANT;
    assign out_active[g] = state == GRANT;
    assign out_sel[g*PORT_BITS +: PORT_BITS] = sel;
    assign out_buf_data[g*SIZE +: SIZE] = data;
`ifdef RX_ARB_DEBUG_EN
    always @(posedge clk)
      if (!reset) begin
        if (state == IDLE && |req) $display("Router %0d: out %0d grant rx %0d", DBG_ID, g, pick);
        if (state == GRANT && out_done[g]) $display("Router %0d: out %0d release rx %0d", DBG_ID, g, sel);
      end
`else
`endif
  end
endmodule

// File: tb/tb_rx_switch_arbiter.sv
// tb_rx_switch_arbiter: directed and randomized check of rx_switch_arbiter against a packet scoreboard
module tb_rx_switch_arbiter;
  localparam int P = 5, PB = 8, S = 8, DB = 7, B = 3000;
  logic clk = 0, reset = 1, rt_ready = 1;
  logic [P-1:0] rx_req = '0, rx_ack, out_req, out_done = '0, out_active;
  logic [P*S-1:0] rx_data = '0, out_buf_data;
  logic [P*DB-1:0] rt_addr;
  logic [P*PB-1:0] rt_data, out_sel;
  logic [P*3-1:0] out_buf_addr = '0;
  logic [7:0] rt_tab [128];
  int vectors = 0, errors = 0, served = 0, target = 0;
  bit running = 0;
  logic [63:0] sb_pkt [P];
  int sb_out [P];
  bit sb_val [P];
  logic [4:0] mask;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < P; i++) rt_data[i*PB +: PB] = rt_tab[rt_addr[i*DB +: DB]];
  rx_switch_arbiter #(.ID(0), .PORTS(P), .PORT_BITS(PB), .SIZE(S)) dut (
    .clk(clk), .reset(reset), .rt_ready(rt_ready), .rx_req(rx_req), .rx_ack(rx_ack),
    .rx_data(rx_data), .rt_addr(rt_addr), .rt_data(rt_data), .out_req(out_req),
    .out_done(out_done), .out_sel(out_sel), .out_active(out_active),
    .out_buf_addr(out_buf_addr), .out_buf_data(out_buf_data)
  );
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_flit(int c, logic [7:0] d);
    int n = 0;
    rx_data[c*S +: S] = d;
    rx_req[c] = 1'b1;
    while (!rx_ack[c] && n < B) begin @(negedge clk); n++; end
    if (!rx_ack[c]) chk("ack_rise_timeout", rx_ack[c], 1);
    rx_req[c] = 1'b0;
    n = 0;
    while (rx_ack[c] && n < B) begin @(negedge clk); n++; end
    if (rx_ack[c]) chk("ack_fall_timeout", rx_ack[c], 0);
  endtask
  task automatic send_pkt(int c, logic [63:0] p);
    for (int k = 0; k < 8; k++) send_flit(c, p[k*8 +: 8]);
  endtask
  task automatic wait_req(int o);
    int n = 0;
    while (!out_req[o] && n < 200) begin @(negedge clk); n++; end
    if (!out_req[o]) chk("grant_timeout", out_req[o], 1);
  endtask
  task automatic read_out(int o, logic [63:0] p, string tag);
    for (int k = 0; k < 8; k++) begin
      out_buf_addr[o*3 +: 3] = 3'(k);
      #1;
      chk(tag, out_buf_data[o*S +: S], p[k*8 +: 8]);
      @(negedge clk);
    end
  endtask
  task automatic release_out(int o);
    out_done[o] = 1'b1;
    @(negedge clk);
    out_done[o] = 1'b0;
  endtask
  task automatic server(int o);
    int j;
    while (running) begin
      if (out_req[o]) begin
        j = int'(out_sel[o*PB +: PB]);
        if (j < P) begin
          chk("rnd_pending", sb_val[j], 1);
          chk("rnd_route", o, sb_out[j]);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          read_out(o, sb_pkt[j], "rnd_data");
          sb_val[j] = 0;
        end else chk("rnd_sel_range", j, 0);
        served++;
        release_out(o);
      end else @(negedge clk);
    end
  endtask
  task automatic rnd_send(int c);
    if (mask[c]) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pkt(c, sb_pkt[c]);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] p, q;
    int n;
    for (int i = 0; i < 128; i++) rt_tab[i] = 8'd7;
    repeat (2) @(negedge clk);
    chk("rst_rx_ack", rx_ack, 0);
    chk("rst_out_req", out_req, 0);
    chk("rst_out_active", out_active, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_rt_addr", rt_addr, 0);
    chk("rst_buf_data", out_buf_data, 0);
    reset = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) send_flit(0, 8'(8'h40 + k));
    rx_data[7:0] = 8'h99;
    rx_req[0] = 1'b1;
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("midrst_rx_ack", rx_ack, 0);
    chk("midrst_rt_addr", rt_addr, 0);
    chk("midrst_out_req", out_req, 0);
    rx_req[0] = 1'b0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    rt_tab[3] = 8'd2;
    p = 64'h8877_6655_4433_2203;
    send_pkt(0, p);
    chk("single_rt_addr", rt_addr[DB-1:0], 7'h03);
    @(negedge clk);
    chk("single_no_early_grant", out_req, 0);
    @(negedge clk);
    chk("single_out_req", out_req, 5'b00100);
    chk("single_out_active", out_active, 5'b00100);
    chk("single_out_sel", out_sel[2*PB +: PB], 0);
    read_out(2, p, "single_data");
    release_out(2);
    chk("single_released", out_req, 0);
    release_out(2);
    chk("idle_done_ignored", out_active, 0);
    rt_tab[8'h11] = 8'd4;
    p = 64'hA1A2_A3A4_A5A6_A711;
    q = 64'hB1B2_B3B4_B5B6_B711;
    fork
      send_pkt(1, p);
      send_pkt(3, q);
    join
    wait_req(4);
    chk("cont_first_sel", out_sel[4*PB +: PB], 1);
    read_out(4, p, "cont_first_data");
    release_out(4);
    chk("cont_gap", out_req[4], 0);
    @(negedge clk);
    chk("cont_second_req", out_req[4], 1);
    chk("cont_second_sel", out_sel[4*PB +: PB], 3);
    read_out(4, q, "cont_second_data");
    release_out(4);
    rt_ready = 0;
    rt_tab[8'h22] = 8'd0;
    p = 64'hC1C2_C3C4_C5C6_C722;
    send_pkt(2, p);
    repeat (4) @(negedge clk);
    chk("gate_blocked", out_req, 0);
    rt_ready = 1;
    @(negedge clk);
    chk("gate_grant", out_req, 5'b00001);
    chk("gate_sel", out_sel[PB-1:0], 2);
    read_out(0, p, "gate_data");
    release_out(0);
    rt_tab[8'h33] = 8'd7;
    send_pkt(4, 64'hD1D2_D3D4_D5D6_D733);
    repeat (3) @(negedge clk);
    chk("bad_no_req", out_req, 0);
    rt_tab[8'h34] = 8'd1;
    p = 64'hE1E2_E3E4_E5E6_E734;
    send_pkt(4, p);
    wait_req(1);
    chk("bad_next_sel", out_sel[PB +: PB], 4);
    read_out(1, p, "bad_next_data");
    release_out(1);
    rt_tab[8'h05] = 8'd1;
    rt_tab[8'h06] = 8'd3;
    p = 64'h1020_3040_5060_7005;
    q = 64'h0F1E_2D3C_4B5A_6906;
    fork
      send_pkt(0, p);
      send_pkt(2, q);
    join
    wait_req(1);
    chk("par_both_req", out_req, 5'b01010);
    chk("par_sel1", out_sel[PB +: PB], 0);
    chk("par_sel3", out_sel[3*PB +: PB], 2);
    for (int k = 0; k < 8; k++) begin
      out_buf_addr[3 +: 3] = 3'(k);
      out_buf_addr[9 +: 3] = 3'(7 - k);
      #1;
      chk("par_data1", out_buf_data[S +: S], p[k*8 +: 8]);
      chk("par_data3", out_buf_data[3*S +: S], q[(7-k)*8 +: 8]);
      @(negedge clk);
    end
    out_done = 5'b01010;
    @(negedge clk);
    out_done = '0;
    chk("par_released", out_req, 0);
    for (int i = 0; i < 128; i++) rt_tab[i] = 8'($urandom_range(0, 6));
    running = 1;
    fork
      server(0);
      server(1);
      server(2);
      server(3);
      server(4);
    join_none
    for (int r = 0; r < 40; r++) begin
      mask = 5'($urandom_range(1, 31));
      target = 0;
      served = 0;
      for (int c = 0; c < P; c++) begin
        sb_pkt[c] = {$urandom, $urandom};
        sb_out[c] = int'(rt_tab[sb_pkt[c][6:0]]);
        sb_val[c] = mask[c] && sb_out[c] < P;
        if (sb_val[c]) target++;
      end
      fork
        rnd_send(0);
        rnd_send(1);
        rnd_send(2);
        rnd_send(3);
        rnd_send(4);
      join
      n = 0;
      while (served < target && n < 1000) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      chk("rnd_served", served, target);
    end
    running = 0;
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
